cache_tag_assoc: RTL and testbench

CACHE_TAG_ASSOC -- requirements
Module: cache_tag_assoc

---
 rtl/cache_tag_assoc.sv | 180 ++++++++++++++++++
 tb/tb_cache_tag_assoc.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_tag_assoc.sv
// ============================================================================
// Module   : cache_tag_assoc
// Function : 2-way set-associative tag store with LRU and a miss/refill FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cache_tag_assoc #(
   parameter int INDEX_W  = 7,
   parameter int OFFSET_W = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_en,
   input  logic [31:0] req_addr,
   output logic        hit,
   output logic        hit_way,
   output logic        stallreq,
   output logic        miss_req,
   output logic [31:0] miss_addr,
   input  logic        miss_ack,
   input  logic        refill_done,
   output logic        refill_way,
   input  logic        inv_all,
   output logic        busy
);

   localparam int c_sets  = 1 << INDEX_W;
   localparam int c_tag_w = 32 - INDEX_W - OFFSET_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_INV  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next;

   logic [c_tag_w-1:0]   r_tag0 [c_sets];
   logic [c_tag_w-1:0]   r_tag1 [c_sets];
   logic [c_sets-1:0]    r_val0;
   logic [c_sets-1:0]    r_val1;
   logic [c_sets-1:0]    r_lru;

   logic [c_tag_w-1:0]   r_cap_tag;
   logic [INDEX_W-1:0]   r_cap_idx;
   logic [INDEX_W-1:0]   r_inv_cnt;
   logic                 r_victim;

   logic [INDEX_W-1:0]   w_idx;
   logic [c_tag_w-1:0]   w_tag;
   logic                 w_m0;
   logic                 w_m1;
   logic                 w_victim;
   logic                 w_fill;
   logic                 w_unused_offset;

   assign w_idx           = req_addr[OFFSET_W +: INDEX_W];
   assign w_tag           = req_addr[31 -: c_tag_w];
   assign w_unused_offset = ^req_addr[OFFSET_W-1:0];

   assign w_m0 = r_val0[w_idx] & (r_tag0[w_idx] == w_tag);
   assign w_m1 = r_val1[w_idx] & (r_tag1[w_idx] == w_tag);

   // Prefer an empty way; only fall back to LRU when the set is full.
   assign w_victim = ~r_val0[w_idx] ? 1'b0 :
                     ~r_val1[w_idx] ? 1'b1 : r_lru[w_idx];

   assign w_fill     = (r_state == ST_WAIT) & refill_done;
   assign busy       = (r_state != ST_IDLE);
   assign miss_addr  = {r_cap_tag, r_cap_idx, {OFFSET_W{1'b0}}};
   assign refill_way = r_victim;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      hit      = 1'b0;
      hit_way  = 1'b0;
      stallreq = 1'b1;
      miss_req = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // inv_all wins over a same-cycle lookup.
            hit      = req_en & ~inv_all & (w_m0 | w_m1);
            hit_way  = hit & ~w_m0;
            stallreq = req_en & ~hit;
            if (inv_all) begin
               w_next = ST_INV;
            end else if (req_en & ~(w_m0 | w_m1)) begin
               w_next = ST_REQ;
            end
         end
         ST_REQ: begin
            miss_req = 1'b1;
            if (miss_ack) begin
               w_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (refill_done) begin
               w_next = ST_IDLE;
            end
         end
         ST_INV: begin
            if (r_inv_cnt == {INDEX_W{1'b1}}) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_val0    <= '0;
         r_val1    <= '0;
         r_lru     <= '0;
         r_cap_tag <= '0;
         r_cap_idx <= '0;
         r_inv_cnt <= '0;
         r_victim  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (inv_all) begin
                  r_inv_cnt <= '0;
               end else if (req_en) begin
                  if (w_m0 | w_m1) begin
                     r_lru[w_idx] <= w_m0;
                  end else begin
                     r_cap_tag <= w_tag;
                     r_cap_idx <= w_idx;
                     r_victim  <= w_victim;
                  end
               end
            end
            ST_WAIT: begin
               if (refill_done) begin
                  if (r_victim) begin
                     r_val1[r_cap_idx] <= 1'b1;
                  end else begin
                     r_val0[r_cap_idx] <= 1'b1;
                  end
                  r_lru[r_cap_idx] <= ~r_victim;
               end
            end
            ST_INV: begin
               r_val0[r_inv_cnt] <= 1'b0;
               r_val1[r_inv_cnt] <= 1'b0;
               r_lru[r_inv_cnt]  <= 1'b0;
               r_inv_cnt         <= r_inv_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Tag RAM carries no reset; the valid bits alone qualify its contents.
   always_ff @(posedge clk) begin
      if (!rst && w_fill) begin
         if (r_victim) begin
            r_tag1[r_cap_idx] <= r_cap_tag;
         end else begin
            r_tag0[r_cap_idx] <= r_cap_tag;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cache_tag_assoc.sv
// ============================================================================
// Module   : tb_cache_tag_assoc
// Function : Directed self-checking bench for cache_tag_assoc with a set model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cache_tag_assoc;

   logic        clk = 1'b0;
   logic        rst, req_en, miss_ack, refill_done, inv_all;
   logic [31:0] req_addr;
   logic        hit, hit_way, stallreq, miss_req, refill_way, busy;
   logic [31:0] miss_addr;

   int n_chk  = 0;
   int n_fail = 0;

   cache_tag_assoc #(.INDEX_W(7), .OFFSET_W(5)) dut (
      .clk(clk), .rst(rst), .req_en(req_en), .req_addr(req_addr),
      .hit(hit), .hit_way(hit_way), .stallreq(stallreq),
      .miss_req(miss_req), .miss_addr(miss_addr), .miss_ack(miss_ack),
      .refill_done(refill_done), .refill_way(refill_way),
      .inv_all(inv_all), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: phase 0 idle, 1 requesting, 2 waiting for data, 3 invalidating.
   logic [19:0] m_tag [2][128];
   bit          m_val [2][128];
   bit          m_lru [128];
   int          m_phase = 0;
   int          m_cnt   = 0;
   logic [31:0] m_cap   = 0;
   bit          m_vic   = 0;
   bit          m_ready = 0;

   function automatic int set_of(input logic [31:0] a);
      return int'((a / 32) % 128);
   endfunction

   function automatic logic [19:0] tag_of(input logic [31:0] a);
      return 20'(a / 4096);
   endfunction

   always @(posedge clk) begin
      int s;
      s = set_of(req_addr);
      if (rst) begin
         for (int i = 0; i < 128; i++) begin
            m_val[0][i] = 0; m_val[1][i] = 0; m_lru[i] = 0;
         end
         m_phase = 0; m_cnt = 0; m_cap = 0; m_vic = 0; m_ready = 1;
      end else if (m_ready) begin
         case (m_phase)
            0: if (inv_all) begin
                  m_phase = 3; m_cnt = 0;
               end else if (req_en) begin
                  if (m_val[0][s] && m_tag[0][s] == tag_of(req_addr))      m_lru[s] = 1;
                  else if (m_val[1][s] && m_tag[1][s] == tag_of(req_addr)) m_lru[s] = 0;
                  else begin
                     m_cap   = req_addr - (req_addr % 32);
                     m_vic   = !m_val[0][s] ? 1'b0 : (!m_val[1][s] ? 1'b1 : m_lru[s]);
                     m_phase = 1;
                  end
               end
            1: if (miss_ack) m_phase = 2;
            2: if (refill_done) begin
                  m_tag[m_vic][set_of(m_cap)] = tag_of(m_cap);
                  m_val[m_vic][set_of(m_cap)] = 1;
                  m_lru[set_of(m_cap)]        = !m_vic;
                  m_phase = 0;
               end
            default: begin
               m_val[0][m_cnt] = 0; m_val[1][m_cnt] = 0; m_lru[m_cnt] = 0;
               m_cnt++;
               if (m_cnt == 128) m_phase = 0;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      int s;
      bit e_hit, e_way;
      if (m_ready) begin
         s = set_of(req_addr);
         e_hit = 0; e_way = 0;
         if (m_phase == 0 && req_en && !inv_all) begin
            if (m_val[0][s] && m_tag[0][s] == tag_of(req_addr)) e_hit = 1;
            else if (m_val[1][s] && m_tag[1][s] == tag_of(req_addr)) begin
               e_hit = 1; e_way = 1;
            end
         end
         chk("m_hit",        32'(hit),        32'(e_hit));
         chk("m_hit_way",    32'(hit_way),    32'(e_way));
         chk("m_stallreq",   32'(stallreq),   (m_phase == 0) ? 32'(req_en && !e_hit) : 32'd1);
         chk("m_miss_req",   32'(miss_req),   32'(m_phase == 1));
         chk("m_miss_addr",  miss_addr,       m_cap);
         chk("m_refill_way", 32'(refill_way), 32'(m_vic));
         chk("m_busy",       32'(busy),       32'(m_phase != 0));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look(input logic [31:0] a, output logic h, output logic w);
      req_en = 1; req_addr = a;
      #1;
      h = hit; w = hit_way;
      tick();
      req_en = 0;
   endtask

   task automatic fill(input logic [31:0] a, output logic h, output logic v);
      req_en = 1; req_addr = a;
      #1;
      h = hit;
      tick();
      req_en = 0;
      #1;
      v = refill_way;
      miss_ack = 1;
      tick();
      miss_ack = 0; refill_done = 1;
      tick();
      refill_done = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic h, w, v;
      int   cyc;
      rst = 1; req_en = 1; req_addr = 32'h1FC0_0000;
      miss_ack = 0; refill_done = 0; inv_all = 0;
      tick(); tick();
      chk("rst_hit", 32'(hit), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_miss_req", 32'(miss_req), 0);
      chk("rst_refill_way", 32'(refill_way), 0);
      chk("rst_miss_addr", miss_addr, 0);
      chk("rst_stallreq", 32'(stallreq), 1);

      // First miss from an empty cache.
      rst = 0;
      #1;
      chk("first_hit", 32'(hit), 0);
      chk("first_stall", 32'(stallreq), 1);
      tick();
      req_en = 0;
      #1;
      chk("first_miss_req", 32'(miss_req), 1);
      chk("first_miss_addr", miss_addr, 32'h1FC0_0000);
      chk("first_refill_way", 32'(refill_way), 0);
      miss_ack = 1; tick(); miss_ack = 0;
      tick(); tick();
      refill_done = 1; tick(); refill_done = 0;
      #1;
      chk("first_busy_low", 32'(busy), 0);
      look(32'h1FC0_0004, h, w);
      chk("refilled_hit", 32'(h), 1);
      chk("refilled_way", 32'(w), 0);

      // LRU replacement in set 0 from a clean state.
      rst = 1; tick(); rst = 0;
      fill(32'h1000_0000, h, v);
      chk("lru_f1_hit", 32'(h), 0);
      chk("lru_f1_way", 32'(v), 0);
      fill(32'h2000_0000, h, v);
      chk("lru_f2_way", 32'(v), 1);
      look(32'h1000_0000, h, w);
      chk("lru_h1", 32'(h), 1);
      chk("lru_h1_way", 32'(w), 0);
      fill(32'h3000_0000, h, v);
      chk("lru_f3_hit", 32'(h), 0);
      chk("lru_f3_way", 32'(v), 1);
      look(32'h1000_0000, h, w);
      chk("lru_keep_hit", 32'(h), 1);
      fill(32'h2000_0000, h, v);
      chk("lru_evicted", 32'(h), 0);

      // Invalidate-all walks every set once.
      inv_all = 1; tick(); inv_all = 0;
      cyc = 0;
      while (busy && cyc < 300) begin
         cyc++;
         tick();
      end
      chk("inv_cycles", 32'(cyc), 128);
      fill(32'h1000_0000, h, v);
      chk("inv_miss_1", 32'(h), 0);
      fill(32'h2000_0000, h, v);
      chk("inv_miss_2", 32'(h), 0);

      // Long miss_req hold; stray inv_all and refill_done are ignored.
      req_en = 1; req_addr = 32'h5000_0040;
      tick();
      req_en = 0;
      for (int i = 0; i < 10; i++) begin
         inv_all = (i == 3); refill_done = (i == 0);
         #1;
         chk("hold_miss_req", 32'(miss_req), 1);
         chk("hold_miss_addr", miss_addr, 32'h5000_0040);
         chk("hold_stall", 32'(stallreq), 1);
         tick();
      end
      inv_all = 0;
      miss_ack = 1; refill_done = 1; tick();
      miss_ack = 0; refill_done = 0;
      #1;
      chk("ack_done_busy", 32'(busy), 1);
      chk("ack_done_mreq", 32'(miss_req), 0);
      refill_done = 1; tick(); refill_done = 0;
      #1;
      chk("hold_done_busy", 32'(busy), 0);
      miss_ack = 1;
      look(32'h5000_0044, h, w);
      miss_ack = 0;
      chk("hold_fill_hit", 32'(h), 1);

      // Reset during WAIT abandons the refill.
      req_en = 1; req_addr = 32'h4000_0000;
      tick();
      req_en = 0; miss_ack = 1; tick(); miss_ack = 0;
      rst = 1; refill_done = 1; tick();
      rst = 0; tick();
      refill_done = 0;
      #1;
      chk("abort_mreq", 32'(miss_req), 0);
      chk("abort_busy", 32'(busy), 0);
      look(32'h4000_0000, h, w);
      chk("abort_miss", 32'(h), 0);
      #1;
      chk("abort_new_mreq", 32'(miss_req), 1);
      miss_ack = 1; tick(); miss_ack = 0;
      refill_done = 1; tick(); refill_done = 0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
